// File: rtl/bp_lce_to_io_link_pkg.sv
// Message formats, widths and configuration enum shared by the LCE-to-I/O link slice.
// Field layouts follow the common BlackParrot LCE/CCE and CCE/mem message headers.
package bp_lce_to_io_link_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_inv_cfg     = 2'd1
  } bp_params_e;

  localparam int unsigned lce_id_width_p    = 4;
  localparam int unsigned cce_id_width_p    = 4;
  localparam int unsigned paddr_width_p     = 40;
  localparam int unsigned dword_width_p     = 64;
  localparam int unsigned cce_block_width_p = 128;
  localparam int unsigned lce_assoc_p       = 8;
  localparam int unsigned way_id_width_p    = $clog2(lce_assoc_p);

  // Every configuration in this slice shares one cache block width.
  function automatic int unsigned bp_block_width(bp_params_e cfg);
    int unsigned w;
    case (cfg)
      e_bp_inv_cfg: w = cce_block_width_p;
      default:      w = cce_block_width_p;
    endcase
    return w;
  endfunction

  typedef enum logic [2:0] {
    e_lce_req_type_rd    = 3'd0,
    e_lce_req_type_wr    = 3'd1,
    e_lce_req_type_uc_rd = 3'd2,
    e_lce_req_type_uc_wr = 3'd3
  } bp_lce_cce_req_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [3:0] {
    e_lce_cmd_sync           = 4'd0,
    e_lce_cmd_set_clear      = 4'd1,
    e_lce_cmd_transfer       = 4'd2,
    e_lce_cmd_writeback      = 4'd3,
    e_lce_cmd_set_tag        = 4'd4,
    e_lce_cmd_set_tag_wakeup = 4'd5,
    e_lce_cmd_invalidate_tag = 4'd6,
    e_lce_cmd_uc_st_done     = 4'd7,
    e_lce_cmd_data           = 4'd8,
    e_lce_cmd_uc_data        = 4'd9
  } bp_lce_cmd_type_e;

  typedef struct packed {
    bp_lce_cce_req_type_e        msg_type;
    logic [lce_id_width_p-1:0]   src_id;
    logic [paddr_width_p-1:0]    addr;
    bp_mem_msg_size_e            size;
  } bp_lce_cce_req_hdr_s;

  typedef struct packed {
    logic [lce_id_width_p-1:0]   lce_id;
    logic [way_id_width_p-1:0]   way_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_cmd_type_e        msg_type;
    logic [paddr_width_p-1:0]    addr;
    bp_mem_msg_size_e            size;
    bp_cce_mem_payload_s         payload;
  } bp_cce_mem_msg_hdr_s;

  typedef struct packed {
    bp_cce_mem_msg_hdr_s         header;
    logic [cce_block_width_p-1:0] data;
  } bp_cce_mem_msg_s;

  typedef struct packed {
    bp_lce_cmd_type_e            msg_type;
    logic [lce_id_width_p-1:0]   dst_id;
    logic [cce_id_width_p-1:0]   src_id;
    logic [way_id_width_p-1:0]   way_id;
    logic [paddr_width_p-1:0]    addr;
    bp_mem_msg_size_e            size;
  } bp_lce_cmd_hdr_s;

  typedef struct packed {
    bp_lce_cmd_hdr_s             header;
    logic [cce_block_width_p-1:0] data;
  } bp_lce_cmd_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);
  localparam int unsigned lce_cmd_width_lp     = $bits(bp_lce_cmd_s);

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO with valid/ready on the write side and valid/yumi on the read side.
// Pointers wrap modulo els_p, so any depth (not just powers of two) is supported.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic [width_p-1:0]      mem_q [els_p];
  logic                    full, empty, push, pop;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  always_comb begin
    full    = (count_q == cnt_width_lp'(els_p));
    empty   = (count_q == '0);
    ready_o = ~full;
    v_o     = ~empty;
    data_o  = mem_q[rptr_q];
    // A full FIFO refuses a push even if a pop frees a slot this cycle.
    push    = v_i & ~full;
    pop     = yumi_i & ~empty;

    rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bp_lce_to_io_link.sv
// Bridges uncached LCE requests to I/O commands and turns I/O responses back into LCE
// commands, remembering each requester's id in an in-order tracker.
module bp_lce_to_io_link
  import bp_lce_to_io_link_pkg::*;
#(
  parameter bp_params_e   bp_params_p              = e_bp_inv_cfg,
  parameter int unsigned  lce_req_max_data_width_p = bp_block_width(bp_params_p),
  parameter int unsigned  max_outstanding_p        = 4,
  localparam int unsigned lce_cce_req_width_lp     =
    $bits(bp_lce_cce_req_hdr_s) + lce_req_max_data_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_id_width_p-1:0]       cce_id_i,

  input  logic [lce_cce_req_width_lp-1:0] lce_req_i,
  input  logic                            lce_req_v_i,
  output logic                            lce_req_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                            io_cmd_v_o,
  input  logic                            io_cmd_ready_i,

  input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                            io_resp_v_i,
  output logic                            io_resp_yumi_o,

  output logic [lce_cmd_width_lp-1:0]     lce_cmd_o,
  output logic                            lce_cmd_v_o,
  input  logic                            lce_cmd_ready_i,

  output logic                            error_o
);

  typedef struct packed {
    bp_lce_cce_req_hdr_s                 header;
    logic [lce_req_max_data_width_p-1:0] data;
  } lce_req_s;

  lce_req_s                  lce_req;
  bp_cce_mem_msg_s           io_cmd;
  bp_cce_mem_msg_s           io_resp;
  bp_lce_cmd_s               resp_cmd;
  bp_lce_cmd_s               out_cmd_q, out_cmd_d;
  logic                      out_v_q, out_v_d;
  logic                      error_q, error_d;

  logic                      req_supported, req_accept, out_full, resp_yumi;
  logic                      tracker_ready, tracker_v, tracker_push;
  logic [lce_id_width_p-1:0] tracker_src_id;

  assign lce_req = lce_req_i;
  assign io_resp = io_resp_i;

  // Request path: purely combinational, gated off while reset is held.
  always_comb begin
    req_supported = (lce_req.header.msg_type == e_lce_req_type_uc_rd)
                  | (lce_req.header.msg_type == e_lce_req_type_uc_wr);
    req_accept    = lce_req_v_i & io_cmd_ready_i & tracker_ready & ~reset_i;
    tracker_push  = req_accept & req_supported;

    io_cmd                 = '0;
    io_cmd.header.msg_type = (lce_req.header.msg_type == e_lce_req_type_uc_wr)
                           ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
    io_cmd.header.addr     = lce_req.header.addr;
    io_cmd.header.size     = lce_req.header.size;
    io_cmd.data            = cce_block_width_p'(lce_req.data[dword_width_p-1:0]);

    // Unsupported types are consumed and dropped; the error flag remembers it.
    error_d = error_q | (req_accept & ~req_supported);
  end

  assign lce_req_yumi_o = req_accept;
  assign io_cmd_v_o     = tracker_push;
  assign io_cmd_o       = io_cmd;

  bsg_fifo_1r1w_small #(
    .width_p (lce_id_width_p),
    .els_p   (max_outstanding_p)
  ) u_tracker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (tracker_push),
    .ready_o (tracker_ready),
    .data_i  (lce_req.header.src_id),
    .v_o     (tracker_v),
    .data_o  (tracker_src_id),
    .yumi_i  (resp_yumi)
  );

  // Response path: the output buffer may drain and reload in the same cycle.
  always_comb begin
    out_full  = out_v_q & ~lce_cmd_ready_i;
    resp_yumi = io_resp_v_i & tracker_v & ~out_full & ~reset_i;

    resp_cmd                 = '0;
    resp_cmd.header.msg_type = (io_resp.header.msg_type == e_cce_mem_uc_wr)
                             ? e_lce_cmd_uc_st_done : e_lce_cmd_uc_data;
    resp_cmd.header.dst_id   = tracker_src_id;
    resp_cmd.header.src_id   = cce_id_i;
    resp_cmd.header.addr     = io_resp.header.addr;
    resp_cmd.header.size     = io_resp.header.size;
    resp_cmd.data            = io_resp.data;

    out_v_d   = resp_yumi | out_full;
    out_cmd_d = resp_yumi ? resp_cmd : out_cmd_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q   <= 1'b0;
      out_cmd_q <= '0;
      error_q   <= 1'b0;
    end else begin
      out_v_q   <= out_v_d;
      out_cmd_q <= out_cmd_d;
      error_q   <= error_d;
    end
  end

  assign io_resp_yumi_o = resp_yumi;
  assign lce_cmd_o      = out_cmd_q;
  assign lce_cmd_v_o    = out_v_q & ~reset_i;
  assign error_o        = error_q & ~reset_i;

  logic unused_bits;
  assign unused_bits = ^{lce_req.data[lce_req_max_data_width_p-1:dword_width_p],
                         io_resp.header.payload};

endmodule
